// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline definitions: result-select and load funct3
// encodings plus the MEM/WB pipeline-register bundle.
package rv32i_pkg;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;
    localparam logic [1:0] RES_IMM  = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic        valid;
        logic        reg_wr;
        logic [4:0]  rd;
        logic [1:0]  result_src;
        logic [2:0]  funct3;
        logic [1:0]  offset;
        logic [31:0] alu_result;
        logic [31:0] load_data;
        logic [31:0] pc_plus4;
        logic [31:0] imm_ext;
    } mem_wb_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load alignment: picks the byte/halfword addressed by the byte offset
// and sign- or zero-extends it; unknown funct3 codes behave as LW.
module load_align
    import rv32i_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed lane, then extend according to the load type
    always_comb begin
        byte_sel = word[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_LB:   value = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  value = {24'h0, byte_sel};
            F3_LH:   value = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  value = {16'h0, half_sel};
            default: value = word;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// RV32I writeback stage: MEM/WB register, result select, register-file write port.
// Define WB_RETIRE_CNT_EN to build the 64-bit retired-instruction counter.
module wb_stage
    import rv32i_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  mem_valid,
    input  logic                  mem_reg_wr,
    input  logic [4:0]            mem_rd_addr,
    input  logic [1:0]            mem_result_src,
    input  logic [2:0]            mem_funct3,
    input  logic [DATA_WIDTH-1:0] mem_alu_result,
    input  logic [DATA_WIDTH-1:0] mem_load_data,
    input  logic [DATA_WIDTH-1:0] mem_pc_plus4,
    input  logic [DATA_WIDTH-1:0] mem_imm_ext,
    output logic                  wr_en,
    output logic [4:0]            wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
`ifdef WB_RETIRE_CNT_EN
    output logic [63:0]           retire_count,
`endif
    output logic                  wb_valid
);

    mem_wb_t     r_q;
    mem_wb_t     r_d;
    logic [31:0] load_val;

    // Pack the incoming MEM-stage fields into the pipeline bundle
    always_comb begin
        r_d            = '0;
        r_d.valid      = mem_valid;
        r_d.reg_wr     = mem_reg_wr;
        r_d.rd         = mem_rd_addr;
        r_d.result_src = mem_result_src;
        r_d.funct3     = mem_funct3;
        r_d.offset     = mem_alu_result[1:0];
        r_d.alu_result = mem_alu_result;
        r_d.load_data  = mem_load_data;
        r_d.pc_plus4   = mem_pc_plus4;
        r_d.imm_ext    = mem_imm_ext;
    end

    // MEM/WB register: reset, then flush (bubble), then stall (hold), else capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (flush) begin
            r_q <= '0;
        end else if (!stall) begin
            r_q <= r_d;
        end
    end

    load_align u_load_align (
        .funct3 (r_q.funct3),
        .offset (r_q.offset),
        .word   (r_q.load_data),
        .value  (load_val)
    );

    // Architectural result select, combinational from the register
    always_comb begin
        case (r_q.result_src)
            RES_ALU:  wr_data = r_q.alu_result;
            RES_LOAD: wr_data = load_val;
            RES_PC4:  wr_data = r_q.pc_plus4;
            default:  wr_data = r_q.imm_ext;
        endcase
    end

    assign wr_en    = r_q.valid & r_q.reg_wr & (r_q.rd != 5'd0);
    assign wr_addr  = r_q.rd;
    assign wb_valid = r_q.valid;

`ifdef WB_RETIRE_CNT_EN
    logic        retire;
    logic [63:0] retire_cnt_q;

    // An occupant retires on the edge where it leaves the stage
    assign retire = r_q.valid & ~reset & (~stall | flush);

    // Free-running retired-instruction counter, wraps naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt_q <= '0;
        end else if (retire) begin
            retire_cnt_q <= retire_cnt_q + 64'd1;
        end
    end

    assign retire_count = retire_cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: directed vector table, hand sequences for
// stall/flush/reset corners, and randomized traffic against a reference model.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic        mem_valid, mem_reg_wr;
    logic [4:0]  mem_rd_addr;
    logic [1:0]  mem_result_src;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_alu_result, mem_load_data, mem_pc_plus4, mem_imm_ext;
    logic        wr_en, wb_valid;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_stage #(.DATA_WIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .mem_valid      (mem_valid),
        .mem_reg_wr     (mem_reg_wr),
        .mem_rd_addr    (mem_rd_addr),
        .mem_result_src (mem_result_src),
        .mem_funct3     (mem_funct3),
        .mem_alu_result (mem_alu_result),
        .mem_load_data  (mem_load_data),
        .mem_pc_plus4   (mem_pc_plus4),
        .mem_imm_ext    (mem_imm_ext),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
`ifdef WB_RETIRE_CNT_EN
        .retire_count   (retire_count),
`endif
        .wb_valid       (wb_valid)
    );

    typedef struct {
        logic        v;
        logic        rw;
        logic [4:0]  rd;
        logic [1:0]  src;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] ld;
        logic [31:0] pc4;
        logic [31:0] imm;
    } ins_t;

    typedef struct {
        string       name;
        ins_t        i;
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
    } vec_t;

    // Reference model: what the stage holds, in result terms
    logic        m_valid;
    logic        m_en;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic [63:0] m_cnt;

    function automatic logic [31:0] ref_value(ins_t i);
        logic [31:0] b;
        logic [31:0] h;
        int off;
        off = int'(i.alu[1:0]);
        b = (i.ld >> (8 * off)) & 32'hFF;
        h = (i.ld >> (16 * (off / 2))) & 32'hFFFF;
        case (i.src)
            2'd0: return i.alu;
            2'd2: return i.pc4;
            2'd3: return i.imm;
            default: begin
                case (i.f3)
                    3'd0: return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
                    3'd4: return b;
                    3'd1: return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
                    3'd5: return h;
                    default: return i.ld;
                endcase
            end
        endcase
    endfunction

    function automatic ins_t rand_ins();
        ins_t i;
        i.v   = 1'($urandom_range(0, 1));
        i.rw  = 1'($urandom_range(0, 1));
        i.rd  = 5'($urandom);
        i.src = 2'($urandom);
        i.f3  = 3'($urandom);
        i.alu = $urandom;
        i.ld  = $urandom;
        i.pc4 = $urandom;
        i.imm = $urandom;
        return i;
    endfunction

    function automatic ins_t mk(logic [4:0] rd, logic [1:0] src, logic [2:0] f3,
                                logic [31:0] alu, logic [31:0] ld, logic [31:0] pc4,
                                logic [31:0] imm);
        ins_t i;
        i.v = 1'b1; i.rw = 1'b1; i.rd = rd; i.src = src; i.f3 = f3;
        i.alu = alu; i.ld = ld; i.pc4 = pc4; i.imm = imm;
        return i;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_model(string tag);
        chk({tag, ".wr_en"}, 64'(wr_en), 64'(m_en));
        chk({tag, ".wr_addr"}, 64'(wr_addr), 64'(m_rd));
        chk({tag, ".wr_data"}, 64'(wr_data), 64'(m_data));
        chk({tag, ".wb_valid"}, 64'(wb_valid), 64'(m_valid));
`ifdef WB_RETIRE_CNT_EN
        chk({tag, ".retire_count"}, retire_count, m_cnt);
`endif
    endtask

    // One clock: drive at negedge, advance model at posedge, check 1ns later
    task automatic step(string tag, logic r, logic s, logic f, ins_t i);
        @(negedge clk);
        reset = r; stall = s; flush = f;
        mem_valid = i.v; mem_reg_wr = i.rw; mem_rd_addr = i.rd;
        mem_result_src = i.src; mem_funct3 = i.f3;
        mem_alu_result = i.alu; mem_load_data = i.ld;
        mem_pc_plus4 = i.pc4; mem_imm_ext = i.imm;
        @(posedge clk);
        if (m_valid && !r && (!s || f)) m_cnt = m_cnt + 64'd1;
        if (r) m_cnt = '0;
        if (r || f) begin
            m_valid = 1'b0; m_en = 1'b0; m_rd = '0; m_data = '0;
        end else if (!s) begin
            m_valid = i.v;
            m_rd    = i.rd;
            m_en    = i.v && i.rw && (i.rd != 5'd0);
            m_data  = ref_value(i);
        end
        #1;
        check_model(tag);
    endtask

    vec_t vecs[$];
    ins_t bub;
    ins_t w;
    logic [63:0] c0;

    initial begin
        m_valid = 0; m_en = 0; m_rd = 0; m_data = 0; m_cnt = 0;
        reset = 1; stall = 0; flush = 0;
        mem_valid = 0; mem_reg_wr = 0; mem_rd_addr = 0; mem_result_src = 0;
        mem_funct3 = 0; mem_alu_result = 0; mem_load_data = 0;
        mem_pc_plus4 = 0; mem_imm_ext = 0;
        bub = mk(5'd0, 2'd0, 3'd0, 0, 0, 0, 0);
        bub.v = 1'b0; bub.rw = 1'b0;

        vecs.push_back('{"alu_rd5", mk(5, 0, 0, 32'h1234_5678, 0, 0, 0), 1, 5, 32'h1234_5678});
        vecs.push_back('{"alu_rd0", mk(0, 0, 0, 32'h1234_5678, 0, 0, 0), 0, 0, 32'h1234_5678});
        vecs.push_back('{"lb_off3", mk(1, 1, 0, 32'h1003, 32'h80FF_7F01, 0, 0), 1, 1, 32'hFFFF_FF80});
        vecs.push_back('{"lbu_off3", mk(2, 1, 4, 32'h2007, 32'h80FF_7F01, 0, 0), 1, 2, 32'h0000_0080});
        vecs.push_back('{"lh_off2", mk(3, 1, 1, 32'h3002, 32'h80FF_7F01, 0, 0), 1, 3, 32'hFFFF_80FF});
        vecs.push_back('{"lhu_off1", mk(4, 1, 5, 32'h4001, 32'h80FF_7F01, 0, 0), 1, 4, 32'h0000_7F01});
        vecs.push_back('{"lw_off2", mk(6, 1, 2, 32'h5002, 32'h80FF_7F01, 0, 0), 1, 6, 32'h80FF_7F01});
        vecs.push_back('{"f3_111_lw", mk(8, 1, 7, 32'h5001, 32'h80FF_7F01, 0, 0), 1, 8, 32'h80FF_7F01});
        vecs.push_back('{"pc4", mk(31, 2, 0, 32'h11, 0, 32'h0000_0208, 0), 1, 31, 32'h0000_0208});
        vecs.push_back('{"lui", mk(9, 3, 0, 32'h11, 0, 0, 32'hABCD_E000), 1, 9, 32'hABCD_E000});
        w = mk(10, 0, 0, 32'h77, 0, 0, 0);
        w.v = 1'b0;
        vecs.push_back('{"invalid", w, 0, 10, 32'h77});
        w = mk(11, 0, 0, 32'h66, 0, 0, 0);
        w.rw = 1'b0;
        vecs.push_back('{"no_regwr", w, 0, 11, 32'h66});

        // Reset with random inputs, then idle release
        step("rst0", 1, 0, 0, rand_ins());
        step("rst1", 1, 1, 1, rand_ins());
        chk("rst.wr_en", 64'(wr_en), 0);
        chk("rst.wr_data", 64'(wr_data), 0);
        step("idle", 0, 0, 0, bub);
        chk("idle.wr_en", 64'(wr_en), 0);

        // Directed vector table
        foreach (vecs[k]) begin
            step(vecs[k].name, 0, 0, 0, vecs[k].i);
            chk({vecs[k].name, ".en"}, 64'(wr_en), 64'(vecs[k].en));
            chk({vecs[k].name, ".addr"}, 64'(wr_addr), 64'(vecs[k].addr));
            chk({vecs[k].name, ".data"}, 64'(wr_data), 64'(vecs[k].data));
        end

        // Stall: occupant held 4 cycles, counted once on leaving
        step("stl_cap", 0, 0, 0, mk(7, 2, 0, 32'h9, 0, 32'h104, 0));
        c0 = m_cnt;
        for (int k = 0; k < 3; k++) begin
            step("stl_hold", 0, 1, 0, rand_ins());
            chk("stall.wr_en", 64'(wr_en), 1);
            chk("stall.wr_addr", 64'(wr_addr), 7);
            chk("stall.wr_data", 64'(wr_data), 32'h104);
        end
`ifdef WB_RETIRE_CNT_EN
        chk("stall.cnt_held", retire_count, c0);
`endif
        step("stl_rel", 0, 0, 0, bub);
`ifdef WB_RETIRE_CNT_EN
        chk("stall.cnt_once", retire_count, c0 + 64'd1);
`endif

        // Flush beats stall and still counts the occupant
        step("fl_cap", 0, 0, 0, mk(12, 0, 0, 32'h55, 0, 0, 0));
        c0 = m_cnt;
        step("fl_both", 0, 1, 1, rand_ins());
        chk("flush.wb_valid", 64'(wb_valid), 0);
        chk("flush.wr_en", 64'(wr_en), 0);
`ifdef WB_RETIRE_CNT_EN
        chk("flush.cnt", retire_count, c0 + 64'd1);
`endif

        // Reset during stall wins
        step("rs_cap", 0, 0, 0, mk(13, 0, 0, 32'h44, 0, 0, 0));
        step("rs_stall", 0, 1, 0, rand_ins());
        step("rs_rst", 1, 1, 0, rand_ins());
        chk("rst_stall.wr_en", 64'(wr_en), 0);
        chk("rst_stall.wr_addr", 64'(wr_addr), 0);
        step("rs_rel", 0, 0, 0, bub);

`ifdef WB_RETIRE_CNT_EN
        // Counter wrap
        step("wr_cap", 0, 0, 0, mk(14, 0, 0, 32'h33, 0, 0, 0));
        force dut.retire_cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.retire_cnt_q;
        m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        step("wr_ret", 0, 0, 0, bub);
        chk("wrap.cnt", retire_count, 0);
`endif

        // Randomized traffic against the model
        for (int k = 0; k < 500; k++) begin
            step("rand",
                 $urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 10,
                 rand_ins());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the pipelined RV32I core: the writer side of the register file's write port. Holds the MEM/WB pipeline register, selects the architectural result (ALU, aligned/extended load data, PC+4, immediate), and drives `wr_en`/`wr_addr`/`wr_data` into the register file, which also forwards them to same-cycle reads. Optionally counts retired instructions.

## Interface
Parameters:
- `DATA_WIDTH`, 32, datapath width; only 32 is supported.

Ports:
- `clk`  in  1  core clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `stall`  in  1  hold the MEM/WB register.
- `flush`  in  1  load a bubble into the MEM/WB register; takes priority over `stall`.
- `mem_valid`  in  1  the MEM stage holds a real instruction.
- `mem_reg_wr`  in  1  the instruction writes `rd`.
- `mem_rd_addr`  in  5  destination register.
- `mem_result_src`  in  2  result select: 00 ALU, 01 load, 10 PC+4, 11 immediate.
- `mem_funct3`  in  3  load type.
- `mem_alu_result`  in  32  ALU result or load address.
- `mem_load_data`  in  32  raw aligned memory word.
- `mem_pc_plus4`  in  32  PC+4 of the instruction.
- `mem_imm_ext`  in  32  extended immediate (LUI).
- `wr_en`  out  1  register-file write enable.
- `wr_addr`  out  5  register-file write address.
- `wr_data`  out  32  register-file write data.
- `wb_valid`  out  1  the WB stage holds a real instruction.
- `retire_count`  out  64  retired-instruction count; present only with `WB_RETIRE_CNT_EN`.

## Operation
- MEM/WB register fields: valid, reg_wr, rd, result_src, funct3, byte offset (`mem_alu_result[1:0]`), alu_result, load_data, pc_plus4, imm_ext.
- Update priority on each rising edge: `reset`, then `flush`, then `stall`, then capture.
  - `reset`: all fields cleared to 0.
  - `flush`: valid=0; other fields are don't-care but are cleared.
  - `stall`: all fields hold.
  - Otherwise: all fields capture the `mem_*` inputs.
- Load alignment, using the registered offset:
  - LB=000 and LBU=100 select byte `offset`.
  - LH=001 and LHU=101 select the halfword at `offset[1]`; `offset[0]` is ignored.
  - LW=010 selects the whole word; offset is ignored.
  - Signed loads sign-extend; unsigned loads zero-extend.
  - Encodings 011, 110 and 111 are treated as LW.
- `wr_data` = the result selected by `result_src`. This path is combinational from the register.
- `wr_en` = valid & reg_wr & (rd != 0). The block never asserts a write to x0.
- `wr_addr` = rd. It is driven even when `wr_en` = 0.
- `wb_valid` = valid.
- While stalled with a valid writer, `wr_en` stays high every cycle with identical data. This is idempotent and required, so forwarding stays correct.

## Timing
- Latency: an instruction presented on `mem_*` at edge N drives `wr_*` from after edge N until the next capture. The register file commits it at edge N+1.
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `wb_valid`=0, `retire_count`=0.
- Reset during a stall or flush: reset wins; all outputs reach their reset values after that edge.
- `flush` and `stall` both high: a bubble is loaded.
- Retire event: `wb_valid` & (!`stall` | `flush` | `reset`=0 … see next bullet). Precisely, retire = `wb_valid` & !`reset` & (!`stall` | `flush`). A stalled occupant is counted exactly once, on the edge where it leaves.
- `retire_count` increments on the edge following a retire event and wraps from 2^64-1 to 0.

## Configuration
- `WB_RETIRE_CNT_EN` defined: the 64-bit `retire_count` register and output port exist.
- `WB_RETIRE_CNT_EN` undefined: no counter is built and the port is absent. All other behaviour is identical.

## Structure
- Shared package `rv32i_pkg` holds:
  - result_src encodings: `RES_ALU`, `RES_LOAD`, `RES_PC4`, `RES_IMM`.
  - load funct3 constants: `F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`.
- One combinational sub-module, `load_align`, takes (funct3, offset, word) and returns the extended value.

## Test plan
- Reset then idle: hold `reset` 2 cycles with random `mem_*` inputs → all outputs 0. Release with `mem_valid`=0 → `wr_en` stays 0.
- ALU writeback: rd=5, src=00, alu=0x1234_5678 → after the next edge `wr_en`=1, `wr_addr`=5, `wr_data`=0x1234_5678. The same instruction with rd=0 → `wr_en`=0.
- Loads, with word 0x80FF_7F01:
  - LB offset 3 → 0xFFFF_FF80.
  - LBU offset 3 → 0x0000_0080.
  - LH offset 2 → 0xFFFF_80FF.
  - LHU offset 1 → 0x0000_7F01.
  - LW offset 2 → 0x80FF_7F01.
- Stall: capture rd=7 with PC+4=0x104, then hold `stall` 3 cycles → `wr_*` constant and `wr_en`=1 for all 4 cycles. `retire_count` increases by exactly 1, after the stall is released.
- Flush priority: `flush`=`stall`=1 with a valid occupant → next cycle `wb_valid`=0, `wr_en`=0, and the occupant is counted once.
- Counter wrap (macro defined): force `retire_count` to 2^64-1 and retire one instruction → `retire_count`=0.
